// File: rtl/fft_pkg.sv
// Shared constants, state encoding and tag payload for the FFT frame sequencer.
package fft_pkg;

  localparam int unsigned FFT_N        = 8;
  localparam int unsigned FFT_CBW      = 3;
  localparam int unsigned CORE_LAT_DEF = 6;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_CLEAR_ENC = 2'd1;
  localparam logic [1:0] ST_RUN_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_CLEAR = ST_CLEAR_ENC,
    ST_RUN   = ST_RUN_ENC
  } fft_state_e;

  // One delay-line slot: marks a core input cycle and its in-frame position.
  typedef struct packed {
    logic               vld;
    logic [FFT_CBW-1:0] pos;
  } fft_tag_t;

  // True for the final position of a frame.
  function automatic logic is_last_pos(input logic [FFT_CBW-1:0] p);
    return p == FFT_CBW'(FFT_N - 1);
  endfunction

endpackage

// File: rtl/fft_frame_fifo.sv
// Circular sample buffer with occupancy count; read data is the current head.
module fft_frame_fifo #(
  parameter int unsigned DBW   = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rstx,
  input  logic                           i_push,
  input  logic [DBW-1:0]                 i_wdata,
  input  logic                           i_pop,
  output logic [DBW-1:0]                 o_rdata_c,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DBW-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_wr;
  logic           w_rd;

  // Pointer advance with wrap for non power-of-two depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign w_rd      = i_pop && (r_count != '0);
  // A write at full is accepted only when a read frees the slot in the same cycle.
  assign w_wr      = i_push && (!o_full_c || w_rd);
  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array, no reset needed on data.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rstx) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for fft_3_8: buffers samples, issues whole frames, tags outputs.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DBW      = 8,
  parameter int unsigned CBW      = FFT_CBW,
  parameter int unsigned FRAMES   = 2,
  parameter int unsigned CORE_LAT = CORE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rstx,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DBW-1:0]   s_data,
  output logic             core_clear,
  output logic [DBW-1:0]   core_din,
  input  logic [2*DBW-1:0] core_dout,
  output logic             m_valid,
  output logic             m_first,
  output logic             m_last,
  output logic [CBW-1:0]   m_idx,
  output logic [2*DBW-1:0] m_data,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned DEPTH = FRAMES * FFT_N;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [DBW-1:0]   w_rdata;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_cnt_after_run;

  fft_state_e       r_state;
  fft_state_e       w_state_nxt;
  logic [CBW-1:0]   r_pos;
  logic [CBW-1:0]   w_pos_nxt;

  logic             r_core_clear;
  logic [DBW-1:0]   r_core_din;
  fft_tag_t         r_in_tag;
  fft_tag_t         r_dl [CORE_LAT];
  fft_tag_t         w_tail;
  logic             w_dl_any;

  logic             r_m_valid;
  logic             r_m_first;
  logic             r_m_last;
  logic [CBW-1:0]   r_m_idx;
  logic [2*DBW-1:0] r_m_data;
  logic [15:0]      r_frame_cnt;

  assign s_ready = !w_full;
  assign w_push  = s_valid && !w_full;

  fft_frame_fifo #(
    .DBW   (DBW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstx      (rstx),
    .i_push    (w_push),
    .i_wdata   (s_data),
    .i_pop     (w_pop),
    .o_rdata_c (w_rdata),
    .o_count   (w_count),
    .o_full_c  (w_full)
  );

  // Occupancy after a RUN cycle, which always pops exactly one sample.
  assign w_cnt_after_run = (CW+1)'(w_count) + (CW+1)'(w_push) - (CW+1)'(1);

  // State and position registers.
  always_ff @(posedge clk) begin
    if (rstx) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  // Next-state: start only on a full frame, chain frames while one is buffered.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_count >= CW'(FFT_N)) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_state_nxt = ST_RUN;
        w_pos_nxt   = '0;
      end
      ST_RUN: begin
        w_pop     = 1'b1;
        w_pos_nxt = r_pos + CBW'(1);
        if ((r_pos == CBW'(FFT_N - 1)) && (w_cnt_after_run < (CW+1)'(FFT_N))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pos_nxt   = '0;
      end
    endcase
  end

  // Core drive: clear lands one cycle ahead of the pos 0 sample.
  always_ff @(posedge clk) begin
    if (rstx) begin
      r_core_clear <= 1'b0;
      r_core_din   <= '0;
      r_in_tag     <= '0;
    end else begin
      r_core_clear <= (r_state == ST_CLEAR);
      r_core_din   <= w_pop ? w_rdata : '0;
      r_in_tag     <= (r_state == ST_RUN) ? fft_tag_t'({1'b1, FFT_CBW'(r_pos)}) : '0;
    end
  end

  // Tag delay line matching the core latency.
  always_ff @(posedge clk) begin
    if (rstx) begin
      for (int i = 0; i < int'(CORE_LAT); i++) r_dl[i] <= '0;
    end else begin
      r_dl[0] <= r_in_tag;
      for (int i = 1; i < int'(CORE_LAT); i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign w_tail = r_dl[CORE_LAT-1];

  // Any bin still travelling through the core.
  always_comb begin
    w_dl_any = r_in_tag.vld;
    for (int i = 0; i < int'(CORE_LAT); i++) w_dl_any = w_dl_any | r_dl[i].vld;
  end

  // Output stage: tag and core result registered together.
  always_ff @(posedge clk) begin
    if (rstx) begin
      r_m_valid   <= 1'b0;
      r_m_first   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_idx     <= '0;
      r_m_data    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_m_valid   <= w_tail.vld;
      r_m_first   <= w_tail.vld && (w_tail.pos == '0);
      r_m_last    <= w_tail.vld && is_last_pos(w_tail.pos);
      r_m_idx     <= w_tail.vld ? CBW'(w_tail.pos) : '0;
      r_m_data    <= w_tail.vld ? core_dout : '0;
      r_frame_cnt <= r_frame_cnt + 16'(r_m_valid && r_m_last);
    end
  end

  assign core_clear = r_core_clear;
  assign core_din   = r_core_din;
  assign m_valid    = r_m_valid;
  assign m_first    = r_m_first;
  assign m_last     = r_m_last;
  assign m_idx      = r_m_idx;
  assign m_data     = r_m_data;
  assign frame_cnt  = r_frame_cnt;
  assign busy       = (r_state != ST_IDLE) || w_dl_any || r_m_valid;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl with a delay-only core model.
module tb_fft_frame_ctrl;

  localparam int unsigned DBW      = 8;
  localparam int unsigned CBW      = 3;
  localparam int unsigned FRAMES   = 2;
  localparam int unsigned CORE_LAT = 6;

  logic             clk;
  logic             rstx;
  logic             s_valid;
  logic             s_ready;
  logic [DBW-1:0]   s_data;
  logic             core_clear;
  logic [DBW-1:0]   core_din;
  logic [2*DBW-1:0] core_dout;
  logic             m_valid;
  logic             m_first;
  logic             m_last;
  logic [CBW-1:0]   m_idx;
  logic [2*DBW-1:0] m_data;
  logic             busy;
  logic [15:0]      frame_cnt;

  logic             f_rst;
  logic             f_push;
  logic             f_pop;
  logic [DBW-1:0]   f_wdata;
  logic [DBW-1:0]   f_rdata;
  logic [4:0]       f_count;
  logic             f_full;

  int n_checks = 0;
  int n_pass   = 0;
  int n_push   = 0;
  int n_clear  = 0;
  int n_beats  = 0;
  int run_len  = 0;
  int bidx     = 0;
  int runs[$];
  logic [DBW-1:0] sb_q[$];
  logic [DBW-1:0] core_pipe [CORE_LAT];
  logic [DBW-1:0] din_hist [40];

  typedef struct {
    int n_first;
    int gap;
    int n_second;
    int exp_mid_clr;
    int exp_clr;
    int exp_frames;
    int exp_run;
  } vec_t;
  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .DBW(DBW), .CBW(CBW), .FRAMES(FRAMES), .CORE_LAT(CORE_LAT)
  ) dut (
    .clk(clk), .rstx(rstx), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_clear(core_clear), .core_din(core_din), .core_dout(core_dout),
    .m_valid(m_valid), .m_first(m_first), .m_last(m_last), .m_idx(m_idx),
    .m_data(m_data), .busy(busy), .frame_cnt(frame_cnt)
  );

  fft_frame_fifo #(.DBW(DBW), .DEPTH(16)) u_fifo_chk (
    .clk(clk), .rstx(f_rst), .i_push(f_push), .i_wdata(f_wdata), .i_pop(f_pop),
    .o_rdata_c(f_rdata), .o_count(f_count), .o_full_c(f_full)
  );

  // Core stand-in: returns core_din after CORE_LAT cycles, zero-extended.
  initial for (int i = 0; i < int'(CORE_LAT); i++) core_pipe[i] = '0;
  always @(posedge clk) begin
    core_pipe[0] <= core_din;
    for (int i = 1; i < int'(CORE_LAT); i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_dout = {DBW'(0), core_pipe[CORE_LAT-1]};

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Scoreboard: every 8 accepted samples form a frame, emitted in push order.
  always @(negedge clk) begin
    if (rstx) begin
      sb_q.delete();
      bidx = 0;
      if (run_len > 0) runs.push_back(run_len);
      run_len = 0;
    end else begin
      if (s_valid && s_ready) begin
        sb_q.push_back(s_data);
        n_push++;
      end
      if (core_clear) n_clear++;
      if (m_valid) begin
        logic [DBW-1:0] e;
        n_beats++;
        run_len++;
        if (sb_q.size() == 0) begin
          check(1'b0, "beat_unexpected", longint'(m_data), -1);
        end else begin
          e = sb_q.pop_front();
          check(m_data == {DBW'(0), e}, "beat_data", longint'(m_data), longint'(e));
          check(int'(m_idx) == bidx, "beat_idx", longint'(m_idx), bidx);
          check(m_first == (bidx == 0), "beat_first", longint'(m_first), longint'(bidx == 0));
          check(m_last == (bidx == 7), "beat_last", longint'(m_last), longint'(bidx == 7));
        end
        bidx = (bidx + 1) % 8;
      end else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    s_valid = 1'b0;
    rstx    = 1'b1;
    @(posedge clk); #1;
    rstx    = 1'b0;
  endtask

  // Push n consecutive samples start, start+1, ...; called at posedge+1.
  task automatic push_vals(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DBW'(start + i);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    repeat (3) @(negedge clk);
    while (busy && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(!busy, "drain_timeout", longint'(busy), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  function automatic int max_run_since(input int r0);
    int m;
    m = 0;
    for (int i = r0; i < runs.size(); i++) if (runs[i] > m) m = runs[i];
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b0, r0, p0, t_clr, t_d1, t_mv, found, ef;
    vecs[0] = '{8,  0,  0, 0, 1, 1, 8};
    vecs[1] = '{24, 0,  0, 0, 1, 3, 24};
    vecs[2] = '{5,  20, 3, 0, 1, 1, 8};
    vecs[3] = '{12, 0,  0, 0, 1, 1, 8};
    vecs[4] = '{10, 30, 6, 1, 2, 2, 8};
    vecs[5] = '{7,  0,  0, 0, 0, 0, 0};

    rstx = 1'b1; s_valid = 1'b0; s_data = '0;
    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
    do_reset();

    // Reset values
    check(s_ready == 1'b1, "rst_s_ready", longint'(s_ready), 1);
    check(core_clear == 1'b0, "rst_core_clear", longint'(core_clear), 0);
    check(core_din == '0, "rst_core_din", longint'(core_din), 0);
    check(m_valid == 1'b0, "rst_m_valid", longint'(m_valid), 0);
    check({m_first, m_last, m_idx} == '0, "rst_m_flags", longint'({m_first, m_last, m_idx}), 0);
    check(m_data == '0, "rst_m_data", longint'(m_data), 0);
    check(busy == 1'b0, "rst_busy", longint'(busy), 0);
    check(frame_cnt == 16'd0, "rst_frame_cnt", longint'(frame_cnt), 0);

    // Single frame: clear/core_din/m_valid timing
    do_reset();
    c0 = n_clear; b0 = n_beats; r0 = runs.size();
    t_clr = -1; t_d1 = -1; t_mv = -1;
    fork
      push_vals(8, 1);
      begin
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          din_hist[t] = core_din;
          if (core_clear && t_clr < 0) t_clr = t;
          if (core_din == DBW'(1) && t_d1 < 0) t_d1 = t;
          if (m_valid && t_mv < 0) t_mv = t;
        end
      end
    join
    @(posedge clk); #1;
    check(n_clear - c0 == 1, "sf_clear_count", n_clear - c0, 1);
    check(t_clr >= 0 && t_d1 == t_clr + 1, "sf_clear_before_din", t_d1, t_clr + 1);
    for (int k = 0; k < 8; k++) begin
      int ix;
      logic [DBW-1:0] got;
      ix  = t_d1 + k;
      got = (t_d1 >= 0 && ix < 40) ? din_hist[ix] : '0;
      check(got == DBW'(k + 1), "sf_core_din_seq", longint'(got), k + 1);
    end
    check(t_d1 >= 0 && t_mv == t_d1 + int'(CORE_LAT) + 1, "sf_out_latency", t_mv - t_d1, CORE_LAT + 1);
    wait_idle(100);
    check(n_beats - b0 == 8, "sf_beats", n_beats - b0, 8);
    check(max_run_since(r0) == 8, "sf_run", max_run_since(r0), 8);
    check(frame_cnt == 16'd1, "sf_frame_cnt", longint'(frame_cnt), 1);

    // Table-driven push patterns
    for (int k = 0; k < 6; k++) begin
      int base;
      base = k * 40 + 1;
      do_reset();
      c0 = n_clear; b0 = n_beats; r0 = runs.size();
      push_vals(vecs[k].n_first, base);
      if (vecs[k].gap > 0) begin
        repeat (vecs[k].gap) @(posedge clk);
        #1;
        check(n_clear - c0 == vecs[k].exp_mid_clr, "tbl_mid_clear", n_clear - c0, vecs[k].exp_mid_clr);
        check(busy == 1'b0, "tbl_mid_busy", longint'(busy), 0);
      end
      push_vals(vecs[k].n_second, base + vecs[k].n_first);
      wait_idle(200);
      check(n_clear - c0 == vecs[k].exp_clr, "tbl_clear", n_clear - c0, vecs[k].exp_clr);
      check(int'(frame_cnt) == vecs[k].exp_frames, "tbl_frame_cnt", longint'(frame_cnt), vecs[k].exp_frames);
      check(n_beats - b0 == 8 * vecs[k].exp_frames, "tbl_beats", n_beats - b0, 8 * vecs[k].exp_frames);
      check(max_run_since(r0) == vecs[k].exp_run, "tbl_run", max_run_since(r0), vecs[k].exp_run);
      check(s_ready == 1'b1, "tbl_s_ready", longint'(s_ready), 1);
    end

    // Reset in the pos=3 cycle of a frame
    do_reset();
    push_vals(8, 1);
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      @(negedge clk);
      if (core_din == DBW'(2)) found = 1;
    end
    check(found == 1, "mr_reach_pos", found, 1);
    @(posedge clk); #1;
    rstx = 1'b1;
    @(posedge clk); #1;
    rstx = 1'b0;
    b0 = n_beats;
    repeat (30) @(posedge clk);
    #1;
    check(n_beats == b0, "mr_no_beats", n_beats - b0, 0);
    check(frame_cnt == 16'd0, "mr_frame_cnt", longint'(frame_cnt), 0);
    check(busy == 1'b0, "mr_busy", longint'(busy), 0);
    push_vals(8, 50);
    wait_idle(100);
    check(n_beats - b0 == 8, "mr_new_frame_beats", n_beats - b0, 8);
    check(frame_cnt == 16'd1, "mr_new_frame_cnt", longint'(frame_cnt), 1);

    // Random stream against the scoreboard
    do_reset();
    p0 = n_push; b0 = n_beats;
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = DBW'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    wait_idle(300);
    ef = (n_push - p0) / 8;
    check(int'(frame_cnt) == ef, "rnd_frame_cnt", longint'(frame_cnt), ef);
    check(n_beats - b0 == 8 * ef, "rnd_beats", n_beats - b0, 8 * ef);

    // Buffer full behaviour on the standalone FIFO
    @(posedge clk); #1;
    f_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check(f_full == 1'b0, "ff_not_full", longint'(f_full), 0);
      f_push = 1'b1; f_wdata = DBW'(100 + i);
      @(posedge clk); #1;
    end
    check(f_count == 5'd16, "ff_count_full", longint'(f_count), 16);
    check(f_full == 1'b1, "ff_full_flag", longint'(f_full), 1);
    f_wdata = DBW'(99);
    @(posedge clk); #1;
    check(f_count == 5'd16, "ff_push_at_full_dropped", longint'(f_count), 16);
    f_pop = 1'b1; f_wdata = DBW'(200);
    check(f_rdata == DBW'(100), "ff_head", longint'(f_rdata), 100);
    @(posedge clk); #1;
    check(f_count == 5'd16, "ff_push_pop_full", longint'(f_count), 16);
    f_push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int e;
      e = (i < 15) ? 101 + i : 200;
      check(f_rdata == DBW'(e), "ff_order", longint'(f_rdata), e);
      @(posedge clk); #1;
    end
    f_pop = 1'b0;
    check(f_count == 5'd0, "ff_empty", longint'(f_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the streaming 8-point FFT core (fft_3_8), which consumes one real sample per cycle with no stall capability.
- Buffers incoming samples behind a valid/ready handshake and releases them to the core only as whole 8-sample frames on consecutive cycles.
- Drives the core's clear pulse for frame alignment and tracks core latency so the output stream carries valid, first, last and bin-index markers.
- Sits between the sample source and fft_3_8; all core ports connect directly to this block.

Parameters:
- DBW, 8, sample width; the core output is 2*DBW ({imag, real}).
- CBW, 3, in-frame position width; the frame length is 2**CBW = 8.
- FRAMES, 2, input buffer capacity in whole frames; depth is FRAMES*8 entries.
- CORE_LAT, 6, cycles from a sample on core_din to its corresponding bin on core_dout; must match the core instance.

Ports:
- clk  in  1  clock.
- rstx  in  1  synchronous reset, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input buffer can accept a sample.
- s_data  in  DBW  input sample.
- core_clear  out  1  to core clear.
- core_din  out  DBW  to core din.
- core_dout  in  2*DBW  from core dout.
- m_valid  out  1  output bin valid.
- m_first  out  1  bin 0 of a frame.
- m_last  out  1  bin 7 of a frame.
- m_idx  out  CBW  output position within the frame, 0..7.
- m_data  out  2*DBW  registered core_dout.
- busy  out  1  FSM not IDLE, or any bin still in flight.
- frame_cnt  out  16  completed output frames; wraps at 2^16.

Behaviour:
- Reset (rstx=1 at a clk edge):
  - All outputs go to 0, except s_ready=1.
  - The buffer is emptied, FSM goes to IDLE, the latency delay line is cleared and frame_cnt is zeroed.
  - Reset mid-frame discards every buffered and in-flight sample; no m_valid follows from pre-reset data.
- Input buffer:
  - Circular FIFO of FRAMES*8 x DBW with an occupancy count.
  - s_ready = (count != FRAMES*8).
  - A push occurs when s_valid && s_ready.
  - Simultaneous push and pop leaves count unchanged, and is legal when full because s_ready is evaluated before the pop.
- FSM states: IDLE, CLEAR, RUN; 3-bit position counter pos.
  - IDLE: core_din=0, core_clear=0. Go to CLEAR when count >= 8.
  - CLEAR: one cycle with core_clear=1, which sets the core counter to 0 for the next cycle. Go to RUN with pos=0.
  - RUN: pop one sample per cycle onto core_din, registered so the sample at pos=k reaches the core in the cycle the core counter equals k; pos increments each cycle.
  - At pos=7: if count after this pop is >= 8, stay in RUN with pos=0 and no clear. The core counter wraps naturally, so back-to-back frames have zero bubbles. Otherwise go to IDLE.
  - A frame is never started with fewer than 8 samples buffered, so there is no underrun mid-frame.
- Output tracking:
  - Delay line of CORE_LAT entries carrying {valid, pos}, fed with {1, pos} in each RUN cycle and {0, 0} otherwise.
  - At the delay-line tail, register: m_valid, m_idx=pos, m_first=(pos==0), m_last=(pos==7), m_data=core_dout.
  - Total latency from a sample on core_din to its bin on m_* is CORE_LAT+1 cycles.
  - There is no output backpressure: the downstream must accept every m_valid beat.
  - frame_cnt increments in the cycle after m_valid && m_last.
- busy = (state != IDLE) || (any delay-line valid) || m_valid.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N = 8;
  - the FSM state encoding localparams (IDLE=0, CLEAR=1, RUN=2);
  - the default CORE_LAT.
- One natural sub-module: fft_frame_fifo, the circular buffer with count and full flag, parameterised on DBW and depth.
- The FSM and delay line stay in fft_frame_ctrl.

Test Plan:
1. Single frame:
   - Stimulus: reset, then push samples 1..8 on consecutive cycles.
   - Required: core_clear pulses once, one cycle before core_din=1; core_din reads 1..8 on 8 consecutive cycles.
   - Required: m_valid is high for exactly 8 cycles starting CORE_LAT+1 cycles after core_din=1, with m_idx 0..7, m_first on idx 0, m_last on idx 7; frame_cnt goes to 1.
2. Back-to-back frames:
   - Stimulus: push 24 samples continuously.
   - Required: exactly one core_clear; RUN lasts 24 contiguous cycles; m_valid stays high for 24 contiguous cycles; frame_cnt=3.
3. Partial frame:
   - Stimulus: push 5 samples, idle 20 cycles, then push 3.
   - Required: no core_clear and no RUN until the 8th push; afterwards identical to scenario 1.
4. Full buffer with FRAMES=2:
   - Stimulus: hold s_valid=1 while the core path is prevented from draining, i.e. pushing 16 samples faster than RUN starts.
   - Required: s_ready drops at count=16 and no sample is lost.
   - Required: on a simultaneous push and pop at full, count stays at 16 and data order is preserved.
5. Reset mid-frame:
   - Stimulus: assert rstx at pos=3 of a frame for one cycle, then release.
   - Required: m_valid stays 0 until a new complete frame is pushed, and frame_cnt=0.
6. Core data passthrough:
   - Stimulus: a core model returning the core_din value delayed by CORE_LAT (zero-extended).
   - Required: m_data equals the sample pushed at matching m_idx for every beat.
